lock_pid_sequencer: RTL and testbench



---
 rtl/lock_pid_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_lock_pid_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_pid_sequencer.sv
// Auto-lock sequencer: sweeps the actuator, catches an error zero crossing,
// hands the loop to the PID with a preset integrator and supervises lock.
module lock_pid_sequencer (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               relock_en_i,
  input  logic signed [13:0] err_i,
  input  logic signed [13:0] sweep_min_i,
  input  logic signed [13:0] sweep_max_i,
  input  logic        [13:0] sweep_step_i,
  input  logic        [15:0] sweep_div_i,
  input  logic        [13:0] thr_i,
  input  logic        [15:0] settle_i,
  input  logic        [7:0]  max_sweeps_i,
  output logic signed [13:0] ctrl_o,
  output logic               out_sel_o,
  output logic               pid_freeze_o,
  output logic               pid_ifreeze_o,
  output logic               int_rst_o,
  output logic signed [13:0] int_rst_val_o,
  output logic        [2:0]  state_o,
  output logic               locked_o,
  output logic               lost_o,
  output logic               fail_o
);

  localparam int unsigned DW = 14;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWEEP  = 3'd1,
    ST_ENGAGE = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAIL   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] ctrl_q, ctrl_d;
  logic                 dir_dn_q, dir_dn_d;
  logic [CW-1:0]        div_q, div_d;
  logic [SW-1:0]        sw_q, sw_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 lost_q, lost_d;
  logic signed [DW-1:0] e1_q, e2_q;
  logic                 pid_on_d;
  logic signed [DW-1:0] rst_val_d;

  logic signed [DW:0]   e1_x, ctrl_x, step_x, min_x, max_x, next_up, next_dn;
  logic [DW:0]          e_abs;
  logic [DW-1:0]        step_eff;
  logic [CW:0]          settle_eff, cnt_inc;
  logic [SW-1:0]        sw_inc;
  logic                 in_win, xing, tick;

  // Error window / crossing detection and sweep arithmetic at 15 bits
  always_comb begin
    e1_x       = {e1_q[DW-1], e1_q};
    e_abs      = e1_q[DW-1] ? (DW+1)'(-e1_x) : (DW+1)'(e1_x);
    in_win     = (e_abs <= {1'b0, thr_i});
    xing       = in_win && (e1_q[DW-1] != e2_q[DW-1]);
    step_eff   = (sweep_step_i == '0) ? DW'(1) : sweep_step_i;
    ctrl_x     = {ctrl_q[DW-1], ctrl_q};
    step_x     = {1'b0, step_eff};
    min_x      = {sweep_min_i[DW-1], sweep_min_i};
    max_x      = {sweep_max_i[DW-1], sweep_max_i};
    next_up    = ctrl_x + step_x;
    next_dn    = ctrl_x - step_x;
    tick       = (div_q >= sweep_div_i);
    settle_eff = (settle_i == '0) ? (CW+1)'(1) : {1'b0, settle_i};
    cnt_inc    = {1'b0, cnt_q} + (CW+1)'(1);
    sw_inc     = sw_q + SW'(1);
  end

  // Next-state, sweep datapath and next output values
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    dir_dn_d  = dir_dn_q;
    div_d     = div_q;
    sw_d      = sw_q;
    cnt_d     = cnt_q;
    lost_d    = lost_q;
    pid_on_d  = 1'b0;
    rst_val_d = '0;
    if (stop_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAIL: begin
          if (start_i) begin
            state_d  = ST_SWEEP;
            ctrl_d   = sweep_min_i;
            dir_dn_d = 1'b0;
            sw_d     = '0;
            div_d    = '0;
            cnt_d    = '0;
            lost_d   = 1'b0;
          end
        end
        ST_SWEEP: begin
          if (xing) begin
            state_d = ST_ENGAGE;
          end else if (tick) begin
            div_d = '0;
            if (!dir_dn_q) begin
              if (next_up >= max_x) begin
                ctrl_d   = sweep_max_i;
                dir_dn_d = 1'b1;
              end else begin
                ctrl_d = next_up[DW-1:0];
              end
            end else if (next_dn <= min_x) begin
              ctrl_d   = sweep_min_i;
              dir_dn_d = 1'b0;
              sw_d     = sw_inc;
              if ((max_sweeps_i != '0) && (sw_inc == max_sweeps_i)) state_d = ST_FAIL;
            end else begin
              ctrl_d = next_dn[DW-1:0];
            end
          end else begin
            div_d = div_q + CW'(1);
          end
        end
        ST_ENGAGE: begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (!in_win) begin
            state_d = ST_SWEEP;
            cnt_d   = '0;
            div_d   = '0;
          end else if (cnt_inc >= settle_eff) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        ST_LOCKED: begin
          if (in_win) begin
            cnt_d = '0;
          end else if (cnt_inc >= settle_eff) begin
            lost_d  = 1'b1;
            cnt_d   = '0;
            div_d   = '0;
            state_d = relock_en_i ? ST_SWEEP : ST_IDLE;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pid_on_d  = (state_d == ST_SETTLE) || (state_d == ST_LOCKED);
    rst_val_d = (state_d == ST_ENGAGE) ? ctrl_d : '0;
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= '0;
      dir_dn_q      <= 1'b0;
      div_q         <= '0;
      sw_q          <= '0;
      cnt_q         <= '0;
      lost_q        <= 1'b0;
      e1_q          <= '0;
      e2_q          <= '0;
      out_sel_o     <= 1'b0;
      pid_freeze_o  <= 1'b1;
      pid_ifreeze_o <= 1'b1;
      int_rst_o     <= 1'b1;
      int_rst_val_o <= '0;
      locked_o      <= 1'b0;
      fail_o        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      dir_dn_q      <= dir_dn_d;
      div_q         <= div_d;
      sw_q          <= sw_d;
      cnt_q         <= cnt_d;
      lost_q        <= lost_d;
      e1_q          <= err_i;
      e2_q          <= e1_q;
      out_sel_o     <= pid_on_d;
      pid_freeze_o  <= !pid_on_d;
      pid_ifreeze_o <= !pid_on_d;
      int_rst_o     <= !pid_on_d;
      int_rst_val_o <= rst_val_d;
      locked_o      <= (state_d == ST_LOCKED);
      fail_o        <= (state_d == ST_FAIL);
    end
  end

  // Direct views of internal registers
  assign ctrl_o  = ctrl_q;
  assign lost_o  = lost_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_lock_pid_sequencer.sv
// Testbench for lock_pid_sequencer: random triangle sweeps against an
// arithmetic sweep model plus directed lock / loss / abort / reset scenarios.
module tb_lock_pid_sequencer;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               start_i, stop_i, relock_en_i;
  logic signed [13:0] err_i, sweep_min_i, sweep_max_i;
  logic        [13:0] sweep_step_i, thr_i;
  logic        [15:0] sweep_div_i, settle_i;
  logic        [7:0]  max_sweeps_i;
  logic signed [13:0] ctrl_o, int_rst_val_o;
  logic               out_sel_o, pid_freeze_o, pid_ifreeze_o, int_rst_o;
  logic        [2:0]  state_o;
  logic               locked_o, lost_o, fail_o;

  int checks   = 0;
  int failures = 0;

  lock_pid_sequencer dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
    .relock_en_i(relock_en_i), .err_i(err_i), .sweep_min_i(sweep_min_i),
    .sweep_max_i(sweep_max_i), .sweep_step_i(sweep_step_i), .sweep_div_i(sweep_div_i),
    .thr_i(thr_i), .settle_i(settle_i), .max_sweeps_i(max_sweeps_i),
    .ctrl_o(ctrl_o), .out_sel_o(out_sel_o), .pid_freeze_o(pid_freeze_o),
    .pid_ifreeze_o(pid_ifreeze_o), .int_rst_o(int_rst_o), .int_rst_val_o(int_rst_val_o),
    .state_o(state_o), .locked_o(locked_o), .lost_o(lost_o), .fail_o(fail_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; start_i = 0; stop_i = 0; relock_en_i = 1; err_i = 14'sd500;
    sweep_min_i = -14'sd100; sweep_max_i = 14'sd100; sweep_step_i = 14'd30;
    sweep_div_i = 16'd1; thr_i = 14'd20; settle_i = 16'd8; max_sweeps_i = 8'd0;
    #12;
    checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    checks++; if (ctrl_o !== 14'sd0 || int_rst_val_o !== 14'sd0) begin failures++; $display("FAIL reset_values ctrl=%0d rstval=%0d exp=0", ctrl_o, int_rst_val_o); end
    checks++; if ({pid_freeze_o, pid_ifreeze_o, int_rst_o} !== 3'b111) begin failures++; $display("FAIL reset_pid got=%b exp=111", {pid_freeze_o, pid_ifreeze_o, int_rst_o}); end
    checks++; if ({out_sel_o, locked_o, lost_o, fail_o} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {out_sel_o, locked_o, lost_o, fail_o}); end
    @(negedge clk_i); rstn_i = 1'b1;
    tick();
  endtask

  // Sweep from start and compare ctrl_o every clock against the triangle model
  task automatic test_sweep(input int mn, input int mx, input int st, input int dv);
    int v, st_eff, ncyc;
    bit dn;
    st_eff = (st == 0) ? 1 : st;
    ncyc = ((2 * (mx - mn) / st_eff) + 4) * (dv + 1);
    sweep_min_i = 14'(mn); sweep_max_i = 14'(mx); sweep_step_i = 14'(st);
    sweep_div_i = 16'(dv); max_sweeps_i = 8'd0; err_i = 14'sd500;
    pulse_start();
    v = mn; dn = 0;
    checks++; if (state_o !== 3'd1 || ctrl_o !== 14'(mn)) begin failures++; $display("FAIL sweep_start state=%0d ctrl=%0d exp state=1 ctrl=%0d", state_o, ctrl_o, mn); end
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (c % (dv + 1) == 0) begin
        if (!dn) begin
          if (v + st_eff >= mx) begin v = mx; dn = 1; end else v = v + st_eff;
        end else begin
          if (v - st_eff <= mn) begin v = mn; dn = 0; end else v = v - st_eff;
        end
      end
      checks++; if (ctrl_o !== 14'(v) || state_o !== 3'd1) begin failures++; $display("FAIL sweep_ctrl cyc=%0d got=%0d state=%0d exp=%0d", c, ctrl_o, state_o, v); end
      checks++; if ($signed(ctrl_o) < $signed(sweep_min_i) || $signed(ctrl_o) > $signed(sweep_max_i)) begin failures++; $display("FAIL sweep_bounds got=%0d exp within [%0d,%0d]", ctrl_o, mn, mx); end
    end
    pulse_stop();
    checks++; if (state_o !== 3'd0 || ctrl_o !== 14'(v)) begin failures++; $display("FAIL sweep_stop state=%0d ctrl=%0d exp state=0 ctrl=%0d", state_o, ctrl_o, v); end
  endtask

  // No crossing with a sweep limit: FAIL after the modelled number of ticks
  task automatic test_fail();
    int v, nt, mn, mx, st, dv, sweeps;
    bit dn;
    mn = -100; mx = 100; st = 30; dv = 1;
    sweep_min_i = 14'(mn); sweep_max_i = 14'(mx); sweep_step_i = 14'(st);
    sweep_div_i = 16'(dv); max_sweeps_i = 8'd2; err_i = 14'sd500;
    v = mn; dn = 0; nt = 0; sweeps = 0;
    while (sweeps < 2) begin
      nt++;
      if (!dn) begin
        if (v + st >= mx) begin v = mx; dn = 1; end else v = v + st;
      end else if (v - st <= mn) begin
        v = mn; dn = 0; sweeps++;
      end else v = v - st;
    end
    pulse_start();
    for (int c = 1; c < nt * (dv + 1); c++) tick();
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL fail_early state=%0d exp=1", state_o); end
    tick();
    checks++; if (state_o !== 3'd5 || fail_o !== 1'b1) begin failures++; $display("FAIL fail_enter state=%0d fail=%b exp state=5 fail=1", state_o, fail_o); end
    repeat (3) tick();
    checks++; if (ctrl_o !== 14'(mn) || state_o !== 3'd5) begin failures++; $display("FAIL fail_hold ctrl=%0d state=%0d exp ctrl=%0d state=5", ctrl_o, state_o, mn); end
    max_sweeps_i = 8'd0;
    pulse_start();
    checks++; if (state_o !== 3'd1 || fail_o !== 1'b0 || ctrl_o !== 14'(mn)) begin failures++; $display("FAIL fail_restart state=%0d fail=%b ctrl=%0d exp 1/0/%0d", state_o, fail_o, ctrl_o, mn); end
    pulse_stop();
  endtask

  // Crossing -> ENGAGE -> SETTLE -> LOCKED, then loss with relock
  task automatic test_lock_and_loss();
    sweep_min_i = 14'sd37; sweep_max_i = 14'sd100; sweep_step_i = 14'd1;
    sweep_div_i = 16'd1000; thr_i = 14'd20; settle_i = 16'd8; relock_en_i = 1'b1;
    err_i = 14'sd40;
    pulse_start();
    repeat (2) tick();
    err_i = -14'sd10;
    tick();
    checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL xing_wait state=%0d exp=1", state_o); end
    tick();
    checks++; if (state_o !== 3'd2 || int_rst_o !== 1'b1 || int_rst_val_o !== 14'sd37) begin failures++; $display("FAIL engage state=%0d int_rst=%b val=%0d exp 2/1/37", state_o, int_rst_o, int_rst_val_o); end
    checks++; if (out_sel_o !== 1'b0 || pid_freeze_o !== 1'b1) begin failures++; $display("FAIL engage_pid out_sel=%b freeze=%b exp 0/1", out_sel_o, pid_freeze_o); end
    err_i = 14'sd5;
    tick();
    checks++; if (state_o !== 3'd3 || out_sel_o !== 1'b1 || pid_freeze_o !== 1'b0 || pid_ifreeze_o !== 1'b0 || int_rst_o !== 1'b0) begin
      failures++; $display("FAIL settle_entry state=%0d sel=%b frz=%b ifrz=%b irst=%b exp 3/1/0/0/0", state_o, out_sel_o, pid_freeze_o, pid_ifreeze_o, int_rst_o); end
    repeat (7) tick();
    checks++; if (state_o !== 3'd3 || locked_o !== 1'b0) begin failures++; $display("FAIL settle_early state=%0d locked=%b exp 3/0", state_o, locked_o); end
    tick();
    checks++; if (state_o !== 3'd4 || locked_o !== 1'b1 || ctrl_o !== 14'sd37) begin failures++; $display("FAIL locked state=%0d locked=%b ctrl=%0d exp 4/1/37", state_o, locked_o, ctrl_o); end
    err_i = 14'sd300;
    repeat (8) tick();
    checks++; if (state_o !== 3'd4 || lost_o !== 1'b0) begin failures++; $display("FAIL loss_early state=%0d lost=%b exp 4/0", state_o, lost_o); end
    tick();
    checks++; if (state_o !== 3'd1 || lost_o !== 1'b1 || locked_o !== 1'b0 || out_sel_o !== 1'b0 || ctrl_o !== 14'sd37) begin
      failures++; $display("FAIL loss state=%0d lost=%b locked=%b sel=%b ctrl=%0d exp 1/1/0/0/37", state_o, lost_o, locked_o, out_sel_o, ctrl_o); end
    pulse_stop();
    checks++; if (state_o !== 3'd0 || lost_o !== 1'b1) begin failures++; $display("FAIL lost_sticky state=%0d lost=%b exp 0/1", state_o, lost_o); end
  endtask

  // A single out-of-window sample in SETTLE drops back to SWEEP
  task automatic test_settle_abort();
    pulse_start();
    checks++; if (lost_o !== 1'b0) begin failures++; $display("FAIL lost_clear got=%b exp=0", lost_o); end
    err_i = -14'sd10;
    repeat (3) tick();
    checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL abort_settle state=%0d exp=3", state_o); end
    err_i = 14'sd300;
    tick();
    checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL abort_hold state=%0d exp=3", state_o); end
    tick();
    checks++; if (state_o !== 3'd1 || ctrl_o !== 14'sd37 || out_sel_o !== 1'b0) begin failures++; $display("FAIL abort state=%0d ctrl=%0d sel=%b exp 1/37/0", state_o, ctrl_o, out_sel_o); end
    pulse_stop();
  endtask

  // Simultaneous start/stop stays idle; stop wins
  task automatic test_priority();
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    checks++; if (state_o !== 3'd0 || ctrl_o !== 14'sd37) begin failures++; $display("FAIL priority state=%0d ctrl=%0d exp 0/37", state_o, ctrl_o); end
  endtask

  // Asynchronous reset while locked
  task automatic test_reset_locked();
    pulse_start();
    err_i = -14'sd10;
    repeat (11) tick();
    checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL relock state=%0d exp=4", state_o); end
    #2 rstn_i = 1'b0;
    #1;
    checks++; if (out_sel_o !== 1'b0 || pid_freeze_o !== 1'b1 || ctrl_o !== 14'sd0 || state_o !== 3'd0 || locked_o !== 1'b0) begin
      failures++; $display("FAIL async_reset sel=%b frz=%b ctrl=%0d state=%0d locked=%b exp 0/1/0/0/0", out_sel_o, pid_freeze_o, ctrl_o, state_o, locked_o); end
    @(posedge clk_i); #3 rstn_i = 1'b1;
    tick();
    checks++; if (state_o !== 3'd0 || ctrl_o !== 14'sd0) begin failures++; $display("FAIL post_reset state=%0d ctrl=%0d exp 0/0", state_o, ctrl_o); end
  endtask

  initial begin
    int mn, span;
    test_reset();
    test_sweep(-100, 100, 30, 1);
    for (int i = 0; i < 3; i++) begin
      mn   = int'($urandom_range(0, 2000)) - 1000;
      span = int'($urandom_range(10, 300));
      test_sweep(mn, mn + span, int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
    end
    test_fail();
    test_lock_and_loss();
    test_settle_abort();
    test_priority();
    test_reset_locked();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
